// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback unit.
// Used by writeback_unit and wb_load_queue.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    // One buffered load result: destination register plus its data.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } lq_entry_t;

    // Which source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_LQ   = 2'd2
    } sel_t;

endpackage

// File: rtl/wb_load_queue.sv
// Load-result FIFO for the writeback unit.
// LQ_DEPTH must be a power of two, so the pointers wrap by natural overflow.
// Per-entry rd/valid vectors are exported for the pending-destination query.
module wb_load_queue
    import wb_pkg::*;
#(
    parameter int DATA_W   = WB_DATA_W,
    parameter int ADDR_W   = WB_ADDR_W,
    parameter int LQ_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             push,
    input  logic [ADDR_W-1:0]                push_rd,
    input  logic [DATA_W-1:0]                push_data,
    input  logic                             pop,
    output logic [ADDR_W-1:0]                head_rd,
    output logic [DATA_W-1:0]                head_data,
    output logic [$clog2(LQ_DEPTH):0]        count,
    output logic                             full,
    output logic                             empty,
    output logic [LQ_DEPTH-1:0][ADDR_W-1:0]  ent_rd,
    output logic [LQ_DEPTH-1:0]              ent_vld
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [LQ_DEPTH-1:0] vld;
    logic [ADDR_W-1:0]   mem_rd   [LQ_DEPTH];
    logic [DATA_W-1:0]   mem_data [LQ_DEPTH];
    logic                push_ok;
    logic                pop_ok;

    assign full    = (count == CNT_W'(LQ_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign head_rd   = mem_rd[rd_ptr];
    assign head_data = mem_data[rd_ptr];
    assign ent_vld   = vld;

    // Expose every slot's destination for the hazard match.
    always_comb begin
        for (int i = 0; i < LQ_DEPTH; i++) begin
            ent_rd[i] = mem_rd[i];
        end
    end

    // Pointers, occupancy and slot-valid bits; cleared by reset so queued loads are discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            // push_ok implies not full, pop_ok implies not empty, so the two
            // slot indices never coincide when both happen in one cycle.
            if (push_ok) begin
                wr_ptr      <= wr_ptr + 1'b1;
                vld[wr_ptr] <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr      <= rd_ptr + 1'b1;
                vld[rd_ptr] <= 1'b0;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage; contents are only meaningful where vld is set, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_rd[wr_ptr]   <= push_rd;
            mem_data[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: merges ALU results and queued load results into the
// register file's single registered write port, with starvation protection
// for the load queue and a pending-destination query for the hazard unit.
// Optional macro WB_FORWARD_EN adds fwd_hit/fwd_data bypass outputs.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int LQ_DEPTH   = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [ADDR_W-1:0]          ld_rd,
    input  logic [DATA_W-1:0]          ld_data,
    output logic                       reg_write,
    output logic [ADDR_W-1:0]          write_reg,
    output logic [DATA_W-1:0]          write_data,
    input  logic [ADDR_W-1:0]          chk_rd,
    output logic                       chk_pending,
    output logic [$clog2(LQ_DEPTH):0]  lq_count
`ifdef WB_FORWARD_EN
    ,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data
`endif
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic                            lq_push;
    logic                            lq_pop;
    logic [ADDR_W-1:0]               lq_head_rd;
    logic [DATA_W-1:0]               lq_head_data;
    logic                            lq_full;
    logic                            lq_empty;
    logic [LQ_DEPTH-1:0][ADDR_W-1:0] lq_ent_rd;
    logic [LQ_DEPTH-1:0]             lq_ent_vld;
    logic [SC_W-1:0]                 starve_cnt;
    logic                            starve_force;
    sel_t                            sel;

    wb_load_queue #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LQ_DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (lq_push),
        .push_rd   (ld_rd),
        .push_data (ld_data),
        .pop       (lq_pop),
        .head_rd   (lq_head_rd),
        .head_data (lq_head_data),
        .count     (lq_count),
        .full      (lq_full),
        .empty     (lq_empty),
        .ent_rd    (lq_ent_rd),
        .ent_vld   (lq_ent_vld)
    );

    // Readiness depends only on registered occupancy: no push into a full queue
    // even when it pops in the same cycle. Loads to r0 are accepted and dropped.
    assign ld_ready     = !lq_full;
    assign lq_push      = ld_valid && ld_ready && (ld_rd != '0);
    assign starve_force = !lq_empty && (starve_cnt == SC_W'(STARVE_MAX));
    assign alu_ready    = !starve_force;
    assign lq_pop       = (sel == SEL_LQ);

    // Arbitration: a starved queue head beats the ALU; an ALU write to r0 frees the port.
    always_comb begin
        sel = SEL_NONE;
        if (starve_force) begin
            sel = SEL_LQ;
        end else if (alu_valid && (alu_rd != '0)) begin
            sel = SEL_ALU;
        end else if (!lq_empty) begin
            sel = SEL_LQ;
        end
    end

    // Count consecutive cycles the waiting queue head lost to the ALU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (lq_empty || lq_pop) begin
            starve_cnt <= '0;
        end else if ((sel == SEL_ALU) && (starve_cnt != SC_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Registered write port; index and data hold their last value while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            reg_write <= (sel != SEL_NONE);
            if (sel == SEL_ALU) begin
                write_reg  <= alu_rd;
                write_data <= alu_data;
            end else if (sel == SEL_LQ) begin
                write_reg  <= lq_head_rd;
                write_data <= lq_head_data;
            end
        end
    end

    // Destination is pending if still queued or being written this cycle; r0 never is.
    always_comb begin
        logic hit;
        hit = reg_write && (write_reg == chk_rd);
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (lq_ent_vld[i] && (lq_ent_rd[i] == chk_rd)) begin
                hit = 1'b1;
            end
        end
        chk_pending = (chk_rd != '0) && hit;
    end

`ifdef WB_FORWARD_EN
    assign fwd_hit  = reg_write && (write_reg == chk_rd) && (chk_rd != '0);
    assign fwd_data = write_data;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: randomized and directed stimulus,
// a queue-based reference model, and a scoreboard monitor on the write port.
module tb_writeback_unit;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int LQ_DEPTH   = 4;
    localparam int STARVE_MAX = 3;
    localparam int CNT_W      = $clog2(LQ_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              alu_valid = 1'b0;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_rd = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] chk_rd = '0;
    logic              chk_pending;
    logic [CNT_W-1:0]  lq_count;
`ifdef WB_FORWARD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    always #5 clk = ~clk;

    writeback_unit #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .LQ_DEPTH   (LQ_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .chk_rd      (chk_rd),
        .chk_pending (chk_pending),
        .lq_count    (lq_count)
`ifdef WB_FORWARD_EN
        ,
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
`endif
    );

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ld_t;

    // Scoreboard of expected register-file writes, tagged with the cycle they must appear.
    wr_t exp_q[$];

    // Reference model state: the load queue as a plain list, the head's loss streak,
    // and what the write port is currently presenting.
    ld_t               mq[$];
    int                sc = 0;
    logic              m_we = 1'b0;
    logic [ADDR_W-1:0] m_reg = '0;
    logic [DATA_W-1:0] m_data = '0;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: one write-port comparison per clock, decoupled from the stimulus.
    logic [ADDR_W-1:0] h_reg = '0;
    logic [DATA_W-1:0] h_data = '0;
    always @(posedge clk) begin
        wr_t e;
        #1;
        cyc++;
        if (!reset_n) begin
            h_reg  = '0;
            h_data = '0;
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("missed_write", 1, 0);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check("wr_en", reg_write, 1);
            check("wr_reg", write_reg, e.rd);
            check("wr_data", write_data, e.data);
            h_reg  = e.rd;
            h_data = e.data;
        end else begin
            check("idle_en", reg_write, 0);
            check("hold_reg", write_reg, h_reg);
            check("hold_data", write_data, h_data);
        end
    end

    // One clock of stimulus: called right after a negedge with inputs driven.
    task automatic step();
        ld_t w;
        bit  have, popd, alu_won, force_m, alu_acc, ld_acc, pend;
        int  pre;
        #1;
        pre     = mq.size();
        force_m = (pre > 0) && (sc == STARVE_MAX);
        check("alu_ready", alu_ready, !force_m);
        check("ld_ready", ld_ready, pre < LQ_DEPTH);
        check("lq_count", lq_count, pre);
        pend = 1'b0;
        if (chk_rd != 0) begin
            foreach (mq[i]) if (mq[i].rd == chk_rd) pend = 1'b1;
            if (m_we && m_reg == chk_rd) pend = 1'b1;
        end
        check("chk_pending", chk_pending, pend);
`ifdef WB_FORWARD_EN
        check("fwd_hit", fwd_hit, m_we && (m_reg == chk_rd) && (chk_rd != 0));
        check("fwd_data", fwd_data, m_data);
`endif
        have = 0; popd = 0; alu_won = 0;
        if (force_m) begin
            w = mq.pop_front(); have = 1; popd = 1;
        end else if (alu_valid && alu_rd != 0) begin
            w.rd = alu_rd; w.data = alu_data; have = 1; alu_won = 1;
        end else if (pre > 0) begin
            w = mq.pop_front(); have = 1; popd = 1;
        end
        alu_acc = alu_valid && !force_m;
        ld_acc  = ld_valid && (pre < LQ_DEPTH);
        if (ld_acc && ld_rd != 0) mq.push_back('{ld_rd, ld_data});
        if (pre == 0 || popd) sc = 0;
        else if (alu_won && sc < STARVE_MAX) sc++;
        if (have) begin
            exp_q.push_back('{cyc + 1, w.rd, w.data});
            m_we = 1'b1; m_reg = w.rd; m_data = w.data;
        end else begin
            m_we = 1'b0;
        end
        @(negedge clk);
        if (alu_acc) alu_valid = 1'b0;
        if (ld_acc)  ld_valid  = 1'b0;
    endtask

    // Offer new transactions only when the source is idle; busy sources hold.
    task automatic gen(input int pa, input int pl);
        int mode;
        if (!alu_valid && $urandom_range(99) < pa) begin
            alu_valid = 1'b1;
            alu_rd    = ($urandom_range(7) == 0) ? '0 : ADDR_W'($urandom_range(31, 1));
            alu_data  = $urandom;
        end
        if (!ld_valid && $urandom_range(99) < pl) begin
            ld_valid = 1'b1;
            ld_rd    = ($urandom_range(7) == 0) ? '0 : ADDR_W'($urandom_range(31, 1));
            ld_data  = $urandom;
        end
        mode = $urandom_range(3);
        case (mode)
            0: chk_rd = '0;
            1: chk_rd = ADDR_W'($urandom_range(31));
            2: chk_rd = (mq.size() > 0) ? mq[$urandom_range(mq.size() - 1)].rd : ADDR_W'($urandom_range(31));
            default: chk_rd = m_reg;
        endcase
    endtask

    task automatic model_reset();
        mq.delete();
        sc = 0;
        m_we = 1'b0; m_reg = '0; m_data = '0;
    endtask

    initial begin
        // Initial reset.
        #2 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_reg_write", reg_write, 0);
        check("rst_lq_count", lq_count, 0);
        model_reset();
        reset_n = 1'b1;
        step();

        // ALU only: rd=5 then rd=0.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; chk_rd = 5'd5;
        step();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0BAD0BAD; chk_rd = 5'd0;
        step();
        step();

        // Queue fill with ALU idle: rd 1..4 in order.
        for (int i = 1; i <= 4; i++) begin
            ld_valid = 1'b1; ld_rd = ADDR_W'(i); ld_data = 32'h100 + 32'(i);
            step();
        end
        step(); step();

        // ALU busy every cycle with continuous loads: queue fills, ld_ready drops.
        for (int i = 0; i < 14; i++) begin
            if (!alu_valid) begin alu_valid = 1'b1; alu_rd = ADDR_W'($urandom_range(31, 1)); alu_data = $urandom; end
            if (!ld_valid)  begin ld_valid = 1'b1; ld_rd = ADDR_W'($urandom_range(31, 1)); ld_data = $urandom; end
            chk_rd = ld_rd;
            step();
        end
        for (int i = 0; i < 20 && (mq.size() > 0 || alu_valid || ld_valid); i++) begin
            gen(0, 0);
            step();
        end

        // Starvation: one load rd=9 behind a stream of ALU writes to rd=7.
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9999_0009; chk_rd = 5'd9;
        for (int i = 0; i < 8; i++) begin
            if (!alu_valid) begin alu_valid = 1'b1; alu_rd = 5'd7; alu_data = $urandom; end
            step();
        end
        alu_valid = 1'b0;
        step(); step();

        // Reset mid-stream with three loads queued.
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd7; alu_data = $urandom;
            ld_valid = 1'b1; ld_rd = ADDR_W'(10 + i); ld_data = 32'hAA00 + 32'(i);
            step();
        end
        check("prereset_model_depth", mq.size(), lq_count);
        reset_n = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
        #1;
        check("midrst_reg_write", reg_write, 0);
        check("midrst_lq_count", lq_count, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        step();

        // Randomized traffic with varying load mix.
        for (int i = 0; i < 800; i++) begin
            case ((i / 100) % 4)
                0: gen(50, 50);
                1: gen(95, 80);
                2: gen(20, 90);
                default: gen(90, 30);
            endcase
            step();
        end

        // Drain everything and confirm the scoreboard emptied.
        for (int i = 0; i < 60 && (mq.size() > 0 || alu_valid || ld_valid); i++) begin
            gen(0, 0);
            step();
        end
        step(); step();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
